// File: rtl/audio_pkg.sv
// Types and constants shared by the flash-to-I2S playback path.
package audio_pkg;

  localparam int CLK_HZ = 25_000_000;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam logic [7:0] SPI_DUMMY      = 8'h00;

  typedef enum logic [3:0] {
    STARTUP, IDLE, WAIT_LEVEL, CMD, ADDR2, ADDR1, ADDR0,
    READ_LO, READ_HI, PUSH, END_BURST
  } state_t;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } sample_t;

endpackage

// File: rtl/startup_timer.sv
// One-shot flash power-up delay with bypass; done stays set until reset.
module startup_timer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic skip,
  output logic fire,
  output logic done
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  // fire is the single cycle in which the delay expires
  assign fire = !done && (skip || cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (fire) begin
      done <= 1'b1;
    end else if (!done) begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flash_playback_ctrl.sv
// Issues READ bursts to SPI flash, packs little-endian 16-bit samples into the
// I2S sample FIFO, keeps it topped up and loops over the audio region.
module flash_playback_ctrl
  import audio_pkg::*;
#(
  parameter int          STARTUP_CYCLES = 1_000_000,
  parameter logic [23:0] START_ADDR     = 24'h100000,
  parameter logic [23:0] END_ADDR       = 24'h1FFFFF,
  parameter int          FIFO_DEPTH     = 512,
  parameter int          REFILL_LEVEL   = 256,
  parameter int          BURST_SAMPLES  = 128,
  parameter int          CS_GAP         = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        skip_delay,
  output logic                        spi_start,
  output logic [7:0]                  spi_tx_byte,
  input  logic                        spi_done,
  input  logic [7:0]                  spi_rx_byte,
  output logic                        cs_n,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        fifo_wr,
  output logic [15:0]                 fifo_wdata,
  output logic [23:0]                 cur_addr,
  output logic                        wrap_pulse,
  output logic                        running
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(BURST_SAMPLES + 1);
  localparam int GW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

  if (REFILL_LEVEL + BURST_SAMPLES > FIFO_DEPTH) begin : g_bad_fifo
    $error("REFILL_LEVEL + BURST_SAMPLES exceeds FIFO_DEPTH");
  end
  if (((END_ADDR - START_ADDR) & 24'h1) == 24'h0) begin : g_bad_region
    $error("audio region must hold an even number of bytes");
  end

  state_t        state, nxt;
  logic          issued;
  sample_t       smp;
  logic [SW-1:0] smp_cnt;
  logic [GW-1:0] gap_cnt;
  logic          last_byte;
  logic          fire, startup_done;
  logic          read_done;

  startup_timer #(.CYCLES(STARTUP_CYCLES)) u_startup (
    .clk  (clk),
    .rst  (rst),
    .skip (skip_delay),
    .fire (fire),
    .done (startup_done)
  );

  assign read_done  = spi_done && (state == READ_LO || state == READ_HI);
  assign fifo_wdata = smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STARTUP;
    else     state <= nxt;
  end

  // byte states abort to END_BURST on enable loss only once their byte is done
  always_comb begin
    nxt = state;
    case (state)
      STARTUP:    if (fire || startup_done) nxt = IDLE;
      IDLE:       if (enable && gap_cnt == GW'(CS_GAP)) nxt = WAIT_LEVEL;
      WAIT_LEVEL: if (!enable) nxt = IDLE;
                  else if (fifo_level < LW'(REFILL_LEVEL)) nxt = CMD;
      CMD:        if (spi_done) nxt = enable ? ADDR2 : END_BURST;
      ADDR2:      if (spi_done) nxt = enable ? ADDR1 : END_BURST;
      ADDR1:      if (spi_done) nxt = enable ? ADDR0 : END_BURST;
      ADDR0:      if (spi_done) nxt = enable ? READ_LO : END_BURST;
      READ_LO:    if (spi_done) nxt = READ_HI;
      READ_HI:    if (spi_done) nxt = PUSH;
      PUSH:       nxt = (smp_cnt == SW'(BURST_SAMPLES - 1) || last_byte || !enable)
                        ? END_BURST : READ_LO;
      END_BURST:  nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued     <= 1'b0;
      cur_addr   <= START_ADDR;
      wrap_pulse <= 1'b0;
      smp        <= '0;
      smp_cnt    <= '0;
      gap_cnt    <= '0;
      last_byte  <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (spi_done)       issued <= 1'b0;
      else if (spi_start) issued <= 1'b1;
      if (read_done) begin
        if (state == READ_LO) smp.lo <= spi_rx_byte;
        else                  smp.hi <= spi_rx_byte;
        if (cur_addr == END_ADDR) begin
          cur_addr   <= START_ADDR;
          wrap_pulse <= 1'b1;
          last_byte  <= 1'b1;
        end else begin
          cur_addr   <= cur_addr + 24'd1;
        end
      end
      if (state == WAIT_LEVEL) begin
        smp_cnt   <= '0;
        last_byte <= 1'b0;
      end
      if (state == PUSH) smp_cnt <= smp_cnt + 1'b1;
      if (state == END_BURST)                   gap_cnt <= '0;
      else if (cs_n && gap_cnt != GW'(CS_GAP))  gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_comb begin
    spi_start   = (state inside {CMD, ADDR2, ADDR1, ADDR0, READ_LO, READ_HI}) && !issued;
    cs_n        = !(state inside {CMD, ADDR2, ADDR1, ADDR0, READ_LO, READ_HI, PUSH});
    fifo_wr     = (state == PUSH);
    running     = !(state == STARTUP || (state == IDLE && !enable));
    spi_tx_byte = 8'h00;
    case (state)
      CMD:              spi_tx_byte = FLASH_CMD_READ;
      ADDR2:            spi_tx_byte = cur_addr[23:16];
      ADDR1:            spi_tx_byte = cur_addr[15:8];
      ADDR0:            spi_tx_byte = cur_addr[7:0];
      READ_LO, READ_HI: spi_tx_byte = SPI_DUMMY;
      default:          spi_tx_byte = 8'h00;
    endcase
  end

endmodule
